// File: rtl/mipi_csi_rx_raw_depacker_16b4lane_pkg.sv
// Shared definitions for the CSI-2 RAW10/12/14 depacker: type codes, group sizes and
// the per-format byte count consumed by one 8-pixel output word.
package mipi_csi_rx_raw_depacker_16b4lane_pkg;

   localparam int unsigned OUT_PIXELS      = 8;
   localparam int unsigned OUT_PIXEL_WIDTH = 16;

   // Accumulator holds at most need-1 + 8 = 21 bytes; 24 leaves headroom for whole words.
   localparam int unsigned AccBytes   = 24;
   localparam int unsigned GroupBytes = 14;

   localparam logic [2:0] CsiRaw10 = 3'h3;
   localparam logic [2:0] CsiRaw12 = 3'h4;
   localparam logic [2:0] CsiRaw14 = 3'h5;

   localparam logic [4:0] NeedRaw10 = 5'd10;
   localparam logic [4:0] NeedRaw12 = 5'd12;
   localparam logic [4:0] NeedRaw14 = 5'd14;

   typedef enum logic [1:0] {
      FmtRaw10,
      FmtRaw12,
      FmtRaw14,
      FmtNone
   } raw_fmt_e;

   function automatic raw_fmt_e decode_fmt(input logic [2:0] csi_type);
      case (csi_type)
         CsiRaw10: return FmtRaw10;
         CsiRaw12: return FmtRaw12;
         CsiRaw14: return FmtRaw14;
         default:  return FmtNone;
      endcase
   endfunction

   // FmtNone returns an unreachable count so no word can ever be emitted for it.
   function automatic logic [4:0] need_bytes(input raw_fmt_e fmt);
      case (fmt)
         FmtRaw10: return NeedRaw10;
         FmtRaw12: return NeedRaw12;
         FmtRaw14: return NeedRaw14;
         default:  return 5'd31;
      endcase
   endfunction

endpackage

// File: rtl/mipi_csi_rx_raw_group_unpack.sv
// Combinational unpack of up to 14 packed RAW bytes into 8 LSB-aligned 16-bit pixels.
module mipi_csi_rx_raw_group_unpack
   import mipi_csi_rx_raw_depacker_16b4lane_pkg::*;
(
   input  logic [GroupBytes*8-1:0]                  bytes_i,
   input  raw_fmt_e                                 fmt_i,
   output logic [OUT_PIXELS*OUT_PIXEL_WIDTH-1:0]    pixels_o
);

   localparam int unsigned Pw = OUT_PIXEL_WIDTH;

   logic [7:0]  b [GroupBytes];
   logic [23:0] lsb;

   for (genvar i = 0; i < GroupBytes; i++) begin : g_bytes
      assign b[i] = bytes_i[8*i +: 8];
   end

   always_comb begin
      pixels_o = '0;
      lsb      = '0;
      case (fmt_i)
         FmtRaw10: begin
            for (int g = 0; g < 2; g++) begin
               for (int n = 0; n < 4; n++) begin
                  pixels_o[Pw*(4*g+n) +: Pw] = {6'b0, b[5*g+n], b[5*g+4][2*n +: 2]};
               end
            end
         end
         FmtRaw12: begin
            for (int g = 0; g < 4; g++) begin
               pixels_o[Pw*(2*g)   +: Pw] = {4'b0, b[3*g],   b[3*g+2][3:0]};
               pixels_o[Pw*(2*g+1) +: Pw] = {4'b0, b[3*g+1], b[3*g+2][7:4]};
            end
         end
         FmtRaw14: begin
            for (int g = 0; g < 2; g++) begin
               lsb = {b[7*g+6], b[7*g+5], b[7*g+4]};
               for (int n = 0; n < 4; n++) begin
                  pixels_o[Pw*(4*g+n) +: Pw] = {2'b0, b[7*g+n], lsb[6*n +: 6]};
               end
            end
         end
         default: pixels_o = '0;
      endcase
   end

endmodule

// File: rtl/mipi_csi_rx_raw_depacker_16b4lane.sv
// CSI-2 RAW10/12/14 payload depacker: 8 bytes/clk in, one word of 8 x 16-bit pixels out
// whenever enough bytes have accumulated, plus an end-of-line pulse per packet.
module mipi_csi_rx_raw_depacker_16b4lane
   import mipi_csi_rx_raw_depacker_16b4lane_pkg::*;
#(
   parameter int unsigned MIPI_GEAR = 16,
   parameter int unsigned LANES     = 4
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic                                     data_valid_i,
   input  logic [MIPI_GEAR*LANES-1:0]               data_i,
   input  logic [15:0]                              packet_length_i,
   input  logic [2:0]                               packet_type_i,
   output logic                                     pixel_valid_o,
   output logic [OUT_PIXELS*OUT_PIXEL_WIDTH-1:0]    pixel_data_o,
   output logic                                     line_end_o,
   output logic                                     err_short_o
);

   localparam int unsigned InBytes = MIPI_GEAR * LANES / 8;

   typedef enum logic [1:0] {StIdle, StActive, StDiscard, StDone} state_e;

   state_e                                  state_q, state_d;
   raw_fmt_e                                fmt_q, fmt_d;
   logic [15:0]                             remain_q, remain_d;
   logic [AccBytes*8-1:0]                   acc_q, acc_d;
   logic [4:0]                              count_q, count_d;
   logic                                    valid_prev_q;
   logic                                    pix_valid_q, pix_valid_d;
   logic [OUT_PIXELS*OUT_PIXEL_WIDTH-1:0]   pix_data_q, pix_data_d;
   logic                                    line_end_q, line_end_d;
   logic                                    err_short_q, err_short_d;

   logic [7:0]                              in_bytes [InBytes];
   logic                                    rise, start, append_en, drop, end_pkt, emit;
   raw_fmt_e                                cur_fmt;
   logic [15:0]                             cur_rem, rem_after;
   logic [3:0]                              take;
   logic [4:0]                              need, count_app, off;
   logic [AccBytes*8-1:0]                   acc_app, acc_shift;
   logic [OUT_PIXELS*OUT_PIXEL_WIDTH-1:0]   unpacked;

   for (genvar i = 0; i < InBytes; i++) begin : g_in_bytes
      assign in_bytes[i] = data_i[8*i +: 8];
   end

   assign rise  = data_valid_i & ~valid_prev_q;
   assign start = (state_q == StIdle) && rise && (decode_fmt(packet_type_i) != FmtNone) &&
                  (packet_length_i != 16'd0);
   assign append_en = start || ((state_q == StActive) && data_valid_i);
   assign drop      = (state_q == StActive) && !data_valid_i;

   // On the first word nothing has been latched yet, so use the live type and length.
   assign cur_fmt   = start ? decode_fmt(packet_type_i) : fmt_q;
   assign cur_rem   = start ? packet_length_i : remain_q;
   assign take      = (cur_rem >= 16'd8) ? 4'd8 : cur_rem[3:0];
   assign rem_after = cur_rem - 16'(take);
   assign need      = need_bytes(cur_fmt);
   assign count_app = count_q + 5'(take);
   assign emit      = append_en && (count_app >= need);
   assign end_pkt   = (append_en && (rem_after == 16'd0)) || drop;

   always_comb begin
      acc_app = acc_q;
      off     = '0;
      for (int i = 0; i < AccBytes; i++) begin
         off = 5'(i) - count_q;
         if ((5'(i) >= count_q) && (off < {1'b0, take})) begin
            acc_app[8*i +: 8] = in_bytes[off[2:0]];
         end
      end
   end

   assign acc_shift = acc_app >> {need, 3'b000};

   mipi_csi_rx_raw_group_unpack u_unpack (
      .bytes_i  (acc_app[GroupBytes*8-1:0]),
      .fmt_i    (cur_fmt),
      .pixels_o (unpacked)
   );

   always_comb begin
      state_d     = state_q;
      fmt_d       = fmt_q;
      remain_d    = remain_q;
      acc_d       = acc_q;
      count_d     = count_q;
      pix_valid_d = emit;
      pix_data_d  = emit ? unpacked : pix_data_q;
      line_end_d  = end_pkt;
      err_short_d = drop && (remain_q != 16'd0);

      if (append_en) begin
         fmt_d    = cur_fmt;
         remain_d = rem_after;
         acc_d    = emit ? acc_shift : acc_app;
         count_d  = emit ? (count_app - need) : count_app;
      end
      // Residual bytes short of a full word are dropped at the end of the line.
      if (end_pkt) begin
         acc_d    = '0;
         count_d  = '0;
         remain_d = '0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = end_pkt ? StDone : StActive;
            end else if (rise) begin
               state_d = StDiscard;
            end
         end
         StActive:  if (end_pkt) state_d = StDone;
         StDiscard: if (!data_valid_i) state_d = StIdle;
         StDone:    if (!data_valid_i) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // Tracked through reset so a packet in flight at reset release is not mistaken for a start.
      valid_prev_q <= data_valid_i;
      if (reset_i) begin
         state_q     <= StIdle;
         fmt_q       <= FmtNone;
         remain_q    <= '0;
         acc_q       <= '0;
         count_q     <= '0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         line_end_q  <= 1'b0;
         err_short_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fmt_q       <= fmt_d;
         remain_q    <= remain_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         line_end_q  <= line_end_d;
         err_short_q <= err_short_d;
      end
   end

   assign pixel_valid_o = pix_valid_q;
   assign pixel_data_o  = pix_data_q;
   assign line_end_o    = line_end_q;
   assign err_short_o   = err_short_q;

endmodule

// File: tb/tb_mipi_csi_rx_raw_depacker_16b4lane.sv
// Directed, table-driven bench for the RAW depacker: one row per clock of inputs and
// the outputs expected just after that clock edge.
module tb_mipi_csi_rx_raw_depacker_16b4lane;

   typedef struct {
      logic         rst;
      logic         v;
      logic [2:0]   typ;
      logic [15:0]  len;
      logic [63:0]  data;
      logic         pv;
      logic [127:0] pd;
      logic         le;
      logic         err;
   } vec_t;

   localparam logic [127:0] P10 = 128'h0377_0332_02ED_02A8_0377_0332_02ED_02A8;
   localparam logic [127:0] P12 = 128'h0345_0126_0345_0126_0345_0126_0345_0126;
   localparam logic [127:0] P14 = {8{16'h3FFF}};
   localparam logic [55:0]  G10 = 56'h00_0000_E4DD_CCBB_AA;
   localparam logic [55:0]  G12 = 56'h00_0000_0000_5634_12;
   localparam logic [63:0]  ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic         clk;
   logic         reset;
   logic         valid;
   logic [63:0]  data;
   logic [15:0]  len;
   logic [2:0]   typ;
   logic         pv;
   logic [127:0] pd;
   logic         le;
   logic         err;

   int n_checks;
   int n_fail;
   int row;
   vec_t tbl[$];

   mipi_csi_rx_raw_depacker_16b4lane #(
      .MIPI_GEAR (16),
      .LANES     (4)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .data_valid_i    (valid),
      .data_i          (data),
      .packet_length_i (len),
      .packet_type_i   (typ),
      .pixel_valid_o   (pv),
      .pixel_data_o    (pd),
      .line_end_o      (le),
      .err_short_o     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word widx of a wire stream that repeats a glen-byte group (byte 0 in the LSBs).
   function automatic logic [63:0] rep_word(input logic [55:0] grp, input int glen,
                                            input int widx);
      logic [63:0] w;
      w = '0;
      for (int b = 0; b < 8; b++) begin
         w[8*b +: 8] = grp[8*((widx*8 + b) % glen) +: 8];
      end
      return w;
   endfunction

   task automatic add(input logic r, input logic v, input logic [2:0] t, input logic [15:0] l,
                      input logic [63:0] d, input logic epv, input logic [127:0] epd,
                      input logic ele, input logic eerr);
      vec_t e;
      e.rst = r; e.v = v; e.typ = t; e.len = l; e.data = d;
      e.pv = epv; e.pd = epd; e.le = ele; e.err = eerr;
      tbl.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) add(1'b0, 1'b0, 3'h0, 16'd0, 64'd0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic apply_check(input vec_t e);
      @(negedge clk);
      reset = e.rst;
      valid = e.v;
      typ   = e.typ;
      len   = e.len;
      data  = e.data;
      @(posedge clk);
      #1;
      n_checks++;
      if (pv !== e.pv) begin
         n_fail++;
         $display("FAIL row %0d pixel_valid_o: got %0b expected %0b", row, pv, e.pv);
      end
      n_checks++;
      if (le !== e.le) begin
         n_fail++;
         $display("FAIL row %0d line_end_o: got %0b expected %0b", row, le, e.le);
      end
      n_checks++;
      if (err !== e.err) begin
         n_fail++;
         $display("FAIL row %0d err_short_o: got %0b expected %0b", row, err, e.err);
      end
      if (e.pv) begin
         n_checks++;
         if (pd !== e.pd) begin
            n_fail++;
            $display("FAIL row %0d pixel_data_o: got %032h expected %032h", row, pd, e.pd);
         end
      end
      row++;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      row      = 0;
      reset    = 1'b1;
      valid    = 1'b0;
      data     = '0;
      len      = '0;
      typ      = '0;

      // Reset state
      add(1'b1, 1'b0, 3'h0, 16'd0, 64'd0, 1'b0, '0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 3'h0, 16'd0, 64'd0, 1'b0, '0, 1'b0, 1'b0);
      idle(1);
      // RAW10, 40 bytes
      for (int k = 0; k < 5; k++)
         add(1'b0, 1'b1, 3'h3, 16'd40, rep_word(G10, 5, k), k >= 1, P10, k == 4, 1'b0);
      idle(2);
      // RAW12, 24 bytes
      for (int k = 0; k < 3; k++)
         add(1'b0, 1'b1, 3'h4, 16'd24, rep_word(G12, 3, k), k >= 1, P12, k == 2, 1'b0);
      idle(2);
      // RAW14, 56 bytes of FF
      for (int k = 0; k < 7; k++)
         add(1'b0, 1'b1, 3'h5, 16'd56, ONES, (k == 1) || (k == 3) || (k == 5) || (k == 6),
             P14, k == 6, 1'b0);
      idle(2);
      // RAW10, 36 bytes with valid held for 6 words: residual dropped, word 6 ignored
      for (int k = 0; k < 6; k++)
         add(1'b0, 1'b1, 3'h3, 16'd36, rep_word(G10, 5, k), (k >= 1) && (k <= 3), P10,
             k == 4, 1'b0);
      idle(2);
      // RAW12, 48 bytes, valid falls after 3 words
      for (int k = 0; k < 3; k++)
         add(1'b0, 1'b1, 3'h4, 16'd48, rep_word(G12, 3, k), k >= 1, P12, 1'b0, 1'b0);
      add(1'b0, 1'b0, 3'h0, 16'd0, 64'd0, 1'b0, '0, 1'b1, 1'b1);
      idle(1);
      // Unsupported type
      for (int k = 0; k < 4; k++)
         add(1'b0, 1'b1, 3'h0, 16'd40, rep_word(G10, 5, k), 1'b0, '0, 1'b0, 1'b0);
      idle(2);
      // Supported type with zero length is discarded
      for (int k = 0; k < 2; k++)
         add(1'b0, 1'b1, 3'h3, 16'd0, rep_word(G10, 5, k), 1'b0, '0, 1'b0, 1'b0);
      idle(2);
      // Single-word packet shorter than one output word
      add(1'b0, 1'b1, 3'h4, 16'd8, rep_word(G12, 3, 0), 1'b0, '0, 1'b1, 1'b0);
      idle(2);

      foreach (tbl[i]) apply_check(tbl[i]);

      // Reset mid-packet with valid held high: nothing restarts until valid toggles.
      begin
         vec_t e;
         for (int k = 0; k < 2; k++) begin
            e = '{1'b0, 1'b1, 3'h3, 16'd40, rep_word(G10, 5, k), k == 1, P10, 1'b0, 1'b0};
            apply_check(e);
         end
         e = '{1'b1, 1'b1, 3'h3, 16'd40, rep_word(G10, 5, 2), 1'b0, '0, 1'b0, 1'b0};
         apply_check(e);
         for (int k = 3; k < 5; k++) begin
            e = '{1'b0, 1'b1, 3'h3, 16'd40, rep_word(G10, 5, k), 1'b0, '0, 1'b0, 1'b0};
            apply_check(e);
         end
         e = '{1'b0, 1'b0, 3'h0, 16'd0, 64'd0, 1'b0, '0, 1'b0, 1'b0};
         apply_check(e);
         for (int k = 0; k < 5; k++) begin
            e = '{1'b0, 1'b1, 3'h3, 16'd40, rep_word(G10, 5, k), k >= 1, P10, k == 4, 1'b0};
            apply_check(e);
         end
         e = '{1'b0, 1'b0, 3'h0, 16'd0, 64'd0, 1'b0, '0, 1'b0, 1'b0};
         apply_check(e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
